// File: rtl/multicycle_adder.sv
// Multi-cycle adder/subtractor.
// WIDTH-bit operands are summed BITS_PER_CYCLE bits per clock through a ripple
// chain of full-adder cells, least significant slice first. The carry between
// slices is held in a register. Start/ready/done handshake. Carry-out and
// signed overflow are reported with the sum.

module multicycle_adder #(
    parameter int WIDTH          = 16,
    parameter int BITS_PER_CYCLE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    // Number of RUN cycles per operation; BITS_PER_CYCLE must divide WIDTH.
    localparam int N     = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                    state;
    state_t                    state_next;

    // Operands shift right one slice per RUN cycle, so the active slice is
    // always at the bottom. op_b is already inverted for subtraction.
    logic [WIDTH-1:0]          op_a;
    logic [WIDTH-1:0]          op_b;
    logic [WIDTH-1:0]          acc;
    logic [WIDTH-1:0]          acc_next;
    logic                      carry;
    logic [CNT_W-1:0]          count;

    logic [BITS_PER_CYCLE-1:0] slice_a;
    logic [BITS_PER_CYCLE-1:0] slice_b;
    logic [BITS_PER_CYCLE-1:0] slice_sum;
    logic                      ripple;
    logic                      slice_cout;
    logic                      msb_cin;
    logic                      last_slice;

    assign slice_a    = op_a[BITS_PER_CYCLE-1:0];
    assign slice_b    = op_b[BITS_PER_CYCLE-1:0];
    assign last_slice = (count == LAST);

    // Ripple chain of full-adder cells for one slice; also captures the carry
    // into the top bit of the slice, which is the MSB carry-in on the last slice.
    always_comb begin
        ripple    = carry;
        msb_cin   = 1'b0;
        slice_sum = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (i == BITS_PER_CYCLE - 1) begin
                msb_cin = ripple;
            end
            slice_sum[i] = slice_a[i] ^ slice_b[i] ^ ripple;
            ripple       = (slice_a[i] & slice_b[i]) | (ripple & (slice_a[i] ^ slice_b[i]));
        end
        slice_cout = ripple;
    end

    // Internal result with the current slice merged into its position.
    always_comb begin
        acc_next = acc;
        acc_next[int'(count) * BITS_PER_CYCLE +: BITS_PER_CYCLE] = slice_sum;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_slice) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: latch operands on accept, add one slice per RUN cycle, and
    // publish sum/cout/ovf only on the edge that enters DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_a  <= '0;
            op_b  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            count <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a  <= a;
                        op_b  <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        count <= '0;
                    end
                end
                RUN: begin
                    op_a  <= op_a >> BITS_PER_CYCLE;
                    op_b  <= op_b >> BITS_PER_CYCLE;
                    carry <= slice_cout;
                    acc   <= acc_next;
                    count <= count + 1'b1;
                    if (last_slice) begin
                        sum  <= acc_next;
                        cout <= slice_cout;
                        ovf  <= msb_cin ^ slice_cout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_adder.sv
// Scoreboard bench for multicycle_adder: three instances (slice widths 4, 1
// and 16) share the stimulus; a monitor pops expected results on each done.

module tb_multicycle_adder;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;

    logic        ready4, done4, cout4, ovf4;
    logic        ready1, done1, cout1, ovf1;
    logic        ready16, done16, cout16, ovf16;
    logic [15:0] sum4, sum1, sum16;

    exp_t q4[$];
    exp_t q1[$];
    exp_t q16[$];

    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;
    bit   rdy_chk4 = 0, rdy_chk1 = 0, rdy_chk16 = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    multicycle_adder #(.WIDTH(16), .BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .ready(ready4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    multicycle_adder #(.WIDTH(16), .BITS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .ready(ready1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
    );

    multicycle_adder #(.WIDTH(16), .BITS_PER_CYCLE(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .ready(ready16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_item(input string tag, input exp_t e, input logic [15:0] s,
                              input logic c, input logic o);
        check({tag, "_sum"}, 32'(s), 32'(e.sum));
        check({tag, "_cout"}, 32'(c), 32'(e.cout));
        check({tag, "_ovf"}, 32'(o), 32'(e.ovf));
        check({tag, "_latency_cycle"}, 32'(cyc), 32'(e.due));
    endtask

    task automatic unexpected(input string tag);
        compared++;
        mismatched++;
        $display("FAIL %s_unexpected_done: got done=1, required no pending result (cycle %0d)", tag, cyc);
    endtask

    // Monitor: compare each done pulse against the head of its queue and
    // check that ready is back on the following cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rdy_chk4)  begin check("dut4_ready_after_done", 32'(ready4), 32'd1);  rdy_chk4  = 0; end
        if (rdy_chk1)  begin check("dut1_ready_after_done", 32'(ready1), 32'd1);  rdy_chk1  = 0; end
        if (rdy_chk16) begin check("dut16_ready_after_done", 32'(ready16), 32'd1); rdy_chk16 = 0; end
        if (done4 === 1'b1) begin
            if (q4.size() == 0) unexpected("dut4");
            else begin e = q4.pop_front(); check_item("dut4", e, sum4, cout4, ovf4); rdy_chk4 = 1; end
        end
        if (done1 === 1'b1) begin
            if (q1.size() == 0) unexpected("dut1");
            else begin e = q1.pop_front(); check_item("dut1", e, sum1, cout1, ovf1); rdy_chk1 = 1; end
        end
        if (done16 === 1'b1) begin
            if (q16.size() == 0) unexpected("dut16");
            else begin e = q16.pop_front(); check_item("dut16", e, sum16, cout16, ovf16); rdy_chk16 = 1; end
        end
    end

    task automatic push_all(input logic [15:0] s, input logic c, input logic o);
        exp_t e;
        e.sum = s; e.cout = c; e.ovf = o;
        e.due = cyc + 1 + 4;  q4.push_back(e);
        e.due = cyc + 1 + 16; q1.push_back(e);
        e.due = cyc + 1 + 1;  q16.push_back(e);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((q4.size() != 0 || q1.size() != 0 || q16.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            compared++;
            mismatched++;
            $display("FAIL drain_timeout: got %0d/%0d/%0d pending, required 0/0/0",
                     q4.size(), q1.size(), q16.size());
            q4.delete(); q1.delete(); q16.delete();
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic do_op(input logic s, input logic [15:0] x, input logic [15:0] y,
                         input logic ci, input logic [15:0] es, input logic ec, input logic eo);
        start = 1'b1; sub = s; a = x; b = y; cin = ci;
        push_all(es, ec, eo);
        @(negedge clk);
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom); sub = ~s; cin = ~ci;
        wait_drain();
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ready4"}, 32'(ready4), 32'd1);
        check({tag, "_ready1"}, 32'(ready1), 32'd1);
        check({tag, "_ready16"}, 32'(ready16), 32'd1);
        check({tag, "_done_all"}, 32'({done4, done1, done16}), 32'd0);
        check({tag, "_sum4"}, 32'(sum4), 32'd0);
        check({tag, "_sum1"}, 32'(sum1), 32'd0);
        check({tag, "_sum16"}, 32'(sum16), 32'd0);
        check({tag, "_flags_all"}, 32'({cout4, ovf4, cout1, ovf1, cout16, ovf16}), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("reset");

        // Plain additions, carry-out, signed overflow, carry-in.
        do_op(1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        do_op(1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op(1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        do_op(1'b0, 16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0, 1'b0);
        // Subtractions; cin must be ignored in sub mode.
        do_op(1'b1, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        do_op(1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1);

        // Start held high while busy must not queue a second operation.
        start = 1'b1; sub = 1'b0; a = 16'h0001; b = 16'h0001; cin = 1'b0;
        push_all(16'h0002, 1'b0, 1'b0);
        @(negedge clk);
        a = 16'hAAAA; b = 16'h5555;
        @(negedge clk);
        start = 1'b0;
        wait_drain();
        repeat (20) @(negedge clk);

        // Reset on the second RUN edge aborts the operation. The single-slice
        // instance has already reached DONE by then, so it alone reports.
        begin
            exp_t e;
            start = 1'b1; sub = 1'b0; a = 16'h1234; b = 16'h4321; cin = 1'b0;
            e.sum = 16'h5555; e.cout = 1'b0; e.ovf = 1'b0; e.due = cyc + 2;
            q16.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_idle("abort");
        repeat (25) @(negedge clk);
        check("abort_no_pending", 32'(q4.size() + q1.size() + q16.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
